pd_readout_arb: RTL and testbench
=================================

// Module: pd_readout_arb
// PURPOSE
//  Round-robin readout scheduler for N_CH trapezoid-filter/peak-detector channels.
//  Each channel presents the head of its 2-deep peak shift register (valid + peak).
//  The block drives each channel's read_shift, pops one peak per grant and forwards
//  it with its channel index over a valid/ready stream to the event packer/readout.
// PARAMETERS
//  N_CH   4    number of peak-detector channels (2..16)
//  WD     24   peak sample width, signed two's complement
//  CH_W   2    channel index width, >= clog2(N_CH)
//  TS_W   32   timestamp width (used only with PD_ARB_TIMESTAMP_EN)
//  STALL_W 16  stall counter width
// PORTS
//  clk           in   1          rising-edge clock, single domain
//  rst_n         in   1          synchronous reset, active low
//  ch_valid      in   N_CH       bit i: channel i head entry holds a peak
//  ch_peak       in   N_CH*WD    channel i peak at [i*WD +: WD]
//  ch_read_shift out  N_CH       bit i: shift/pop channel i head this cycle
//  out_valid     out  1          forwarded peak available
//  out_ready     in   1          downstream accepts when out_valid & out_ready
//  out_peak      out  WD         forwarded peak, signed
//  out_ch        out  CH_W       source channel of out_peak
//  out_ts        out  TS_W       grant timestamp (present only with PD_ARB_TIMESTAMP_EN)
//  stall_cnt     out  STALL_W    saturating count of out_valid & !out_ready cycles
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, rr_ptr=0, out_valid=0, out_peak=0, out_ch=0,
//   ch_read_shift=0 (no pops during reset; channel contents preserved), stall_cnt=0.
//  Reset mid-HOLD discards the held peak; it was already popped, so it is lost (documented).
//  FSM: IDLE, HOLD.
//  IDLE: g = first i with ch_valid[i]=1 scanning rr_ptr, rr_ptr+1, ... mod N_CH.
//   - if g found: capture out_peak<=ch_peak[g], out_ch<=g, out_valid<=1, -> HOLD;
//     ch_read_shift[g]=1 combinationally in this same cycle (exactly one pop).
//   - bubble flush: in IDLE, ch_read_shift[i]=1 for every i with ch_valid[i]=0, so
//     invalid heads advance and queued peaks reach the head; never asserted on a valid
//     head other than g.
//  HOLD: ch_read_shift=0 for all channels (no flush while holding).
//   - out_valid&out_ready: out_valid<=0, rr_ptr<=(out_ch+1) mod N_CH, -> IDLE.
//   - else stay; out_peak/out_ch stable; stall_cnt+=1, saturates at 2^STALL_W-1.
//  Latency: ch_valid seen in IDLE at cycle t -> out_valid=1 at t+1; max throughput one
//   peak per 2 cycles (IDLE+HOLD). No combinational path from out_ready to ch_read_shift.
//  Fairness: a channel with a pending peak is granted within N_CH grants.
//  Simultaneous valid on all channels: strict rotation from rr_ptr, one per grant.
//  rr_ptr wraps N_CH-1 -> 0; non-power-of-2 N_CH handled by explicit mod compare.
//  Arithmetic: peak data passed unmodified, sign preserved; no width change.
// CONFIGURATION
//  PD_ARB_TIMESTAMP_EN defined: free-running TS_W counter (reset 0, wraps), sampled to
//   out_ts in the IDLE grant cycle; out_ts held stable through HOLD; reset value 0.
//  Not defined: no counter, no out_ts port; all other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 3 cycles with ch_valid=4'b1111 -> ch_read_shift=0, out_valid=0, stall_cnt=0.
//  2 Single: ch_valid=4'b0100, ch_peak[2]=24'sd1234, out_ready=1 -> next cycle out_valid=1,
//    out_peak=1234, out_ch=2; ch_read_shift=4'b1111 during grant cycle (pop+flush).
//  3 Round-robin: ch_valid=4'b1111 held, peaks 10,20,30,40, out_ready=1 -> out_ch order
//    0,1,2,3,0; out_valid every other cycle.
//  4 Backpressure: out_ready=0 for 5 cycles with peak -500 held -> out_peak=-500 stable,
//    ch_read_shift=0, stall_cnt=5; out_ready=1 -> accepted, back to IDLE next cycle.
//  5 Reset mid-HOLD: grant ch1, then rst_n=0 one cycle -> out_valid=0, rr_ptr=0, next grant ch0.
//  6 PD_ARB_TIMESTAMP_EN: grant at counter=100 with out_ready=0 for 3 cycles -> out_ts=100 held.

Source files
------------

// File: rtl/pd_readout_arb.sv
// Round-robin readout scheduler: pops one peak per grant from N_CH peak detectors.
// Optional grant timestamp when PD_ARB_TIMESTAMP_EN is defined.
module pd_readout_arb #(
    parameter int N_CH    = 4,
    parameter int WD      = 24,
    parameter int CH_W    = 2,
`ifdef PD_ARB_TIMESTAMP_EN
    parameter int TS_W    = 32,
`endif
    parameter int STALL_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        ch_valid,
    input  logic [N_CH*WD-1:0]     ch_peak,
    output logic [N_CH-1:0]        ch_read_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [WD-1:0]   out_peak,
    output logic [CH_W-1:0]        out_ch,
`ifdef PD_ARB_TIMESTAMP_EN
    output logic [TS_W-1:0]        out_ts,
`endif
    output logic [STALL_W-1:0]     stall_cnt
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                state_q, state_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic signed [WD-1:0]  out_peak_q, out_peak_d;
    logic [CH_W-1:0]       out_ch_q, out_ch_d;
    logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
`ifdef PD_ARB_TIMESTAMP_EN
    logic [TS_W-1:0]       ts_q, ts_d;
    logic [TS_W-1:0]       out_ts_q, out_ts_d;
`endif

    logic                  gnt_found;
    logic [CH_W-1:0]       gnt_ch;
    logic [N_CH-1:0]       gnt_oh;
    int                    idx;

    // Scan rr_ptr, rr_ptr+1, ... with explicit wrap so any N_CH works.
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        gnt_oh    = '0;
        idx       = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!gnt_found && ch_valid[idx]) begin
                gnt_found   = 1'b1;
                gnt_ch      = CH_W'(idx);
                gnt_oh[idx] = 1'b1;
            end
        end
    end

    // Pop the grant and flush empty heads; nothing moves while holding or in reset.
    always_comb begin
        if (rst_n && state_q == IDLE)
            ch_read_shift = ~ch_valid | gnt_oh;
        else
            ch_read_shift = '0;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_peak_d  = out_peak_q;
        out_ch_d    = out_ch_q;
        stall_cnt_d = stall_cnt_q;
`ifdef PD_ARB_TIMESTAMP_EN
        ts_d        = ts_q + TS_W'(1);
        out_ts_d    = out_ts_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    out_peak_d  = ch_peak[int'(gnt_ch)*WD +: WD];
                    out_ch_d    = gnt_ch;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
`ifdef PD_ARB_TIMESTAMP_EN
                    out_ts_d    = ts_q;
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                    if (out_ch_q == CH_W'(N_CH - 1))
                        rr_ptr_d = '0;
                    else
                        rr_ptr_d = out_ch_q + CH_W'(1);
                end else if (stall_cnt_q != '1) begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_peak_q  <= '0;
            out_ch_q    <= '0;
            stall_cnt_q <= '0;
`ifdef PD_ARB_TIMESTAMP_EN
            ts_q        <= '0;
            out_ts_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_peak_q  <= out_peak_d;
            out_ch_q    <= out_ch_d;
            stall_cnt_q <= stall_cnt_d;
`ifdef PD_ARB_TIMESTAMP_EN
            ts_q        <= ts_d;
            out_ts_q    <= out_ts_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_peak  = out_peak_q;
    assign out_ch    = out_ch_q;
    assign stall_cnt = stall_cnt_q;
`ifdef PD_ARB_TIMESTAMP_EN
    assign out_ts    = out_ts_q;
`endif

endmodule

// File: tb/tb_pd_readout_arb.sv
// Directed vector bench for pd_readout_arb (N_CH=4, WD=24).
// Timestamp sequence runs only when PD_ARB_TIMESTAMP_EN is defined.
module tb_pd_readout_arb;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [3:0]         ch_valid;
    logic [95:0]        ch_peak;
    logic [3:0]         ch_read_shift;
    logic               out_valid;
    logic               out_ready;
    logic signed [23:0] out_peak;
    logic [1:0]         out_ch;
    logic [15:0]        stall_cnt;
`ifdef PD_ARB_TIMESTAMP_EN
    logic [31:0]        out_ts;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pd_readout_arb #(
        .N_CH(4), .WD(24), .CH_W(2),
`ifdef PD_ARB_TIMESTAMP_EN
        .TS_W(32),
`endif
        .STALL_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ch_valid(ch_valid), .ch_peak(ch_peak),
        .ch_read_shift(ch_read_shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_peak(out_peak), .out_ch(out_ch),
`ifdef PD_ARB_TIMESTAMP_EN
        .out_ts(out_ts),
`endif
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic               rst_n;
        logic [3:0]         v;
        logic [95:0]        pk;
        logic               rdy;
        logic [3:0]         e_rs;
        logic               e_val;
        logic signed [23:0] e_pk;
        logic [1:0]         e_ch;
        logic [15:0]        e_st;
    } vec_t;

    vec_t tv[$];

    function automatic logic [95:0] pk(input int a, input int b, input int c, input int d);
        logic [23:0] a24, b24, c24, d24;
        a24 = a[23:0]; b24 = b[23:0]; c24 = c[23:0]; d24 = d[23:0];
        return {d24, c24, b24, a24};
    endfunction

    task automatic add(input int r, input int v, input logic [95:0] p, input int rdy,
                       input int rs, input int val, input int epk, input int ch, input int st);
        vec_t t;
        t.rst_n = r[0];   t.v = v[3:0];     t.pk = p;          t.rdy = rdy[0];
        t.e_rs = rs[3:0]; t.e_val = val[0]; t.e_pk = epk[23:0]; t.e_ch = ch[1:0];
        t.e_st = st[15:0];
        tv.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [95:0] p3;
        p3 = pk(10, 20, 30, 40);
        //   rst v      peaks               rdy rs     val pk    ch st
        add(0, 4'hF, pk(1,2,3,4),      1, 4'h0, 0, 0,    0, 0);
        add(0, 4'hF, pk(1,2,3,4),      1, 4'h0, 0, 0,    0, 0);
        add(0, 4'hF, pk(1,2,3,4),      1, 4'h0, 0, 0,    0, 0);
        add(1, 4'h4, pk(0,0,1234,0),   1, 4'hF, 0, 0,    0, 0);
        add(1, 4'h0, pk(0,0,0,0),      1, 4'h0, 1, 1234, 2, 0);
        add(1, 4'h0, pk(0,0,0,0),      1, 4'hF, 0, 1234, 2, 0);
        add(0, 4'h0, pk(0,0,0,0),      1, 4'h0, 0, 1234, 2, 0);
        add(1, 4'hF, p3,               1, 4'h1, 0, 0,    0, 0);
        add(1, 4'hF, p3,               1, 4'h0, 1, 10,   0, 0);
        add(1, 4'hF, p3,               1, 4'h2, 0, 10,   0, 0);
        add(1, 4'hF, p3,               1, 4'h0, 1, 20,   1, 0);
        add(1, 4'hF, p3,               1, 4'h4, 0, 20,   1, 0);
        add(1, 4'hF, p3,               1, 4'h0, 1, 30,   2, 0);
        add(1, 4'hF, p3,               1, 4'h8, 0, 30,   2, 0);
        add(1, 4'hF, p3,               1, 4'h0, 1, 40,   3, 0);
        add(1, 4'hF, p3,               1, 4'h1, 0, 40,   3, 0);
        add(1, 4'hF, p3,               1, 4'h0, 1, 10,   0, 0);
        add(1, 4'h2, pk(0,-500,0,0),   0, 4'hF, 0, 10,   0, 0);
        for (int s = 0; s < 5; s++)
            add(1, 4'h2, pk(0,-500,0,0), 0, 4'h0, 1, -500, 1, s);
        add(1, 4'h2, pk(0,-500,0,0),   1, 4'h0, 1, -500, 1, 5);
        add(1, 4'h0, pk(0,0,0,0),      1, 4'hF, 0, -500, 1, 5);

        rst_n = 1'b0; ch_valid = '0; ch_peak = '0; out_ready = 1'b1;
        @(negedge clk);

        foreach (tv[i]) begin
            @(negedge clk);
            rst_n = tv[i].rst_n; ch_valid = tv[i].v;
            ch_peak = tv[i].pk;  out_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d.rs", i),    64'(ch_read_shift), 64'(tv[i].e_rs));
            chk($sformatf("v%0d.valid", i), 64'(out_valid),     64'(tv[i].e_val));
            chk($sformatf("v%0d.peak", i),  64'(out_peak),      64'(tv[i].e_pk));
            chk($sformatf("v%0d.ch", i),    64'(out_ch),        64'(tv[i].e_ch));
            chk($sformatf("v%0d.stall", i), 64'(stall_cnt),     64'(tv[i].e_st));
        end

        // Reset while holding a peak: rr_ptr must restart at 0 (ch3 would win from rr_ptr=2).
        @(negedge clk);
        rst_n = 1'b1; ch_valid = 4'h2; ch_peak = pk(0, 77, 0, 0); out_ready = 1'b0;
        #1 chk("mid.grant_rs", 64'(ch_read_shift), 64'hF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid.hold_valid", 64'(out_valid), 64'd1);
        chk("mid.hold_ch",    64'(out_ch),    64'd1);
        chk("mid.hold_peak",  64'(out_peak),  64'd77);
        chk("mid.rst_rs",     64'(ch_read_shift), 64'h0);
        @(negedge clk);
        rst_n = 1'b1; ch_valid = 4'hB; ch_peak = pk(5, 0, 0, 9); out_ready = 1'b1;
        #1;
        chk("mid.post_valid", 64'(out_valid),     64'd0);
        chk("mid.post_ch",    64'(out_ch),        64'd0);
        chk("mid.post_stall", 64'(stall_cnt),     64'd0);
        chk("mid.post_rs",    64'(ch_read_shift), 64'h5);
        @(negedge clk);
        ch_valid = 4'h0;
        #1;
        chk("mid.regrant_valid", 64'(out_valid), 64'd1);
        chk("mid.regrant_ch",    64'(out_ch),    64'd0);
        chk("mid.regrant_peak",  64'(out_peak),  64'd5);

`ifdef PD_ARB_TIMESTAMP_EN
        @(negedge clk);
        rst_n = 1'b0; ch_valid = 4'h0; out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        ch_valid = 4'h1; ch_peak = pk(-7, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ch_valid = 4'h0;
            #1;
            chk($sformatf("ts.hold%0d", c),  64'(out_ts),    64'd100);
            chk($sformatf("ts.valid%0d", c), 64'(out_valid), 64'd1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
